// File: rtl/hbmultints_pkg.sv
// Shared hexbus definitions: word width, interrupt prefix and interrupt-word builder.
package hbmultints_pkg;

  localparam int unsigned WORD_W    = 34;
  localparam int unsigned PREFIX_W  = 5;
  localparam int unsigned MAX_TAG_W = 4;

  localparam logic [PREFIX_W-1:0] DEF_INT_PREFIX = 5'b11010;

  typedef logic [WORD_W-1:0] hb_word_t;

  // Output register contents plus its bookkeeping flags
  typedef struct packed {
    logic     stb;
    logic     busy;
    logic     loaded;
    logic     int_loaded;
    hb_word_t word;
  } out_reg_t;

  // Channel-0 word is identical to the legacy single-interrupt word
  function automatic hb_word_t make_int_word(input logic [PREFIX_W-1:0] prefix,
                                             input logic [MAX_TAG_W-1:0] tag);
    return {prefix, (WORD_W - PREFIX_W)'(tag)};
  endfunction

endpackage

// File: rtl/hbmultints_if.sv
// Word-stream bus between the response source, the interrupt inserter and the encoder.
interface hbmultints_if;
  import hbmultints_pkg::*;

  logic     i_stb;
  hb_word_t i_word;
  logic     o_int_busy;
  logic     o_int_stb;
  hb_word_t o_int_word;
  logic     i_busy;

  modport master (output i_stb, i_word, i_busy,
                  input  o_int_busy, o_int_stb, o_int_word);

  modport slave  (input  i_stb, i_word, i_busy,
                  output o_int_busy, o_int_stb, o_int_word);

endinterface

// File: rtl/hbmultints_hbintarb.sv
// Round-robin arbiter over interrupt channels; pointer moves past the last accepted channel.
module hbintarb #(
  parameter int unsigned NINT   = 4,
  parameter int unsigned LGNINT = (NINT > 1) ? $clog2(NINT) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NINT-1:0]   request,
  input  logic              advance,
  input  logic [LGNINT-1:0] accepted,
  output logic [NINT-1:0]   grant_c,
  output logic [LGNINT-1:0] grant_idx_c
);

  logic [LGNINT-1:0] rr_ptr;
  logic              found_c;
  int unsigned       idx_c;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      rr_ptr <= '0;
    else if (advance)
      rr_ptr <= (32'(accepted) == NINT - 1) ? '0 : accepted + LGNINT'(1);
  end

  // First requester at or after the pointer, wrapping at NINT
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found_c     = 1'b0;
    idx_c       = 0;
    for (int unsigned i = 0; i < NINT; i++) begin
      idx_c = 32'(rr_ptr) + i;
      if (idx_c >= NINT)
        idx_c = idx_c - NINT;
      if (!found_c && request[LGNINT'(idx_c)]) begin
        found_c                     = 1'b1;
        grant_c[LGNINT'(idx_c)]     = 1'b1;
        grant_idx_c                 = LGNINT'(idx_c);
      end
    end
  end

endmodule

// File: rtl/hbmultints.sv
// Merges NINT interrupt lines into the hexbus return word stream; data words win.
module hbmultints
  import hbmultints_pkg::*;
#(
  parameter int unsigned          NINT       = 4,
  parameter int unsigned          LGNINT     = (NINT > 1) ? $clog2(NINT) : 1,
  parameter logic [PREFIX_W-1:0]  INT_PREFIX = DEF_INT_PREFIX,
  parameter bit                   OPT_LEVEL  = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NINT-1:0] i_interrupt,
  hbmultints_if.slave     bus
);

  logic [NINT-1:0]   pending, pending_n;
  logic [NINT-1:0]   armed, armed_n;
  logic [NINT-1:0]   clear_c, req_c, grant_c;
  logic [LGNINT-1:0] tag, grant_idx_c;
  logic              accept_int_c, data_load_c;
  out_reg_t          oreg, oreg_n;

  assign tag          = oreg.word[LGNINT-1:0];
  assign accept_int_c = oreg.stb && !bus.i_busy && oreg.int_loaded;
  assign data_load_c  = bus.i_stb && !oreg.busy;
  assign req_c        = pending & ~clear_c;

  assign bus.o_int_stb  = oreg.stb;
  assign bus.o_int_word = oreg.word;
  assign bus.o_int_busy = oreg.busy;

  hbintarb #(.NINT(NINT), .LGNINT(LGNINT)) u_arb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .request     (req_c),
    .advance     (accept_int_c),
    .accepted    (tag),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Event capture: a new event beats a same-cycle acknowledge
  always_comb begin
    clear_c   = '0;
    pending_n = pending;
    armed_n   = armed;
    for (int unsigned k = 0; k < NINT; k++) begin
      clear_c[LGNINT'(k)] = accept_int_c && (tag == LGNINT'(k));
      if (i_interrupt[LGNINT'(k)] && (OPT_LEVEL || !armed[LGNINT'(k)])) begin
        pending_n[LGNINT'(k)] = 1'b1;
        armed_n[LGNINT'(k)]   = 1'b1;
      end else begin
        if (clear_c[LGNINT'(k)])
          pending_n[LGNINT'(k)] = 1'b0;
        if (!pending[LGNINT'(k)] && !i_interrupt[LGNINT'(k)])
          armed_n[LGNINT'(k)] = 1'b0;
      end
    end
  end

  // Output register load: data, else granted interrupt when the slot is free
  always_comb begin
    oreg_n = oreg;
    if (data_load_c) begin
      oreg_n.word       = bus.i_word;
      oreg_n.stb        = 1'b1;
      oreg_n.loaded     = 1'b1;
      oreg_n.int_loaded = 1'b0;
    end else if (!oreg.stb || !bus.i_busy) begin
      oreg_n.word       = make_int_word(INT_PREFIX, MAX_TAG_W'(grant_idx_c));
      oreg_n.stb        = |grant_c;
      oreg_n.loaded     = 1'b0;
      oreg_n.int_loaded = 1'b1;
    end
    oreg_n.busy = oreg_n.stb && oreg_n.loaded;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending <= '0;
      armed   <= '0;
      oreg    <= '{stb: 1'b0, busy: 1'b0, loaded: 1'b0, int_loaded: 1'b1,
                   word: make_int_word(INT_PREFIX, '0)};
    end else begin
      pending <= pending_n;
      armed   <= armed_n;
      oreg    <= oreg_n;
    end
  end

`ifdef FORMAL
  a_data_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (oreg.stb && oreg.loaded && bus.i_busy) |=> (oreg.stb && $stable(oreg.word)));
  a_single_report: assert property (@(posedge i_clk) disable iff (i_reset)
    accept_int_c |=> !(oreg.stb && oreg.int_loaded && oreg.word == $past(oreg.word)));
  a_int_loaded: assert property (@(posedge i_clk)
    oreg.int_loaded == (oreg.word[WORD_W-1 -: PREFIX_W] == INT_PREFIX));
`endif

endmodule

// File: tb/tb_hbmultints.sv
// Directed bench for hbmultints: edge-mode DUT checked cycle by cycle, level-mode DUT for re-pend.
module tb_hbmultints;

  localparam int unsigned NINT = 4;
  localparam logic [33:0] IW0  = 34'h3_4000_0000;
  localparam logic [4:0]  PFX  = 5'b11010;
  localparam logic [33:0] D1   = 34'h0_1234_5678;
  localparam logic [33:0] D2   = 34'h0_0ABC_DEF0;
  localparam logic [33:0] D3   = 34'h0_0000_00AA;

  typedef struct {
    logic        stb;
    logic [33:0] word;
    logic        busy;
    logic [3:0]  irq;
    logic        e_stb;
    logic [33:0] e_word;
    logic        e_busy;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NINT-1:0] irq;
  int              checks = 0;
  int              errors = 0;
  vec_t            vq[$];

  int   e_int_cnt[NINT] = '{default: 0};
  int   l_int_cnt[NINT] = '{default: 0};
  int   e_data_cnt = 0;
  int   l_b2b = 0;
  logic l_prev = 1'b0;

  hbmultints_if bus_e ();
  hbmultints_if bus_l ();

  hbmultints #(.NINT(NINT), .OPT_LEVEL(1'b0)) u_edge (
    .i_clk(clk), .i_reset(rst), .i_interrupt(irq), .bus(bus_e.slave));

  hbmultints #(.NINT(NINT), .OPT_LEVEL(1'b1)) u_lvl (
    .i_clk(clk), .i_reset(rst), .i_interrupt(irq), .bus(bus_l.slave));

  always #5 clk = ~clk;

  // Tally words the encoder takes at the coming edge
  always @(negedge clk) begin
    logic l_acc;
    if (bus_e.o_int_stb && !bus_e.i_busy) begin
      if (bus_e.o_int_word[33:29] == PFX) e_int_cnt[bus_e.o_int_word[1:0]] += 1;
      else e_data_cnt += 1;
    end
    if (bus_l.o_int_stb && !bus_l.i_busy && bus_l.o_int_word[33:29] == PFX)
      l_int_cnt[bus_l.o_int_word[1:0]] += 1;
    l_acc = bus_l.o_int_stb && !bus_l.i_busy && bus_l.o_int_word[33:29] == PFX &&
            bus_l.o_int_word[1:0] == 2'd1;
    if (l_acc && l_prev) l_b2b += 1;
    l_prev = l_acc;
  end

  function automatic logic [33:0] iw(input int k);
    return IW0 | 34'(k);
  endfunction

  function automatic int e_int_total();
    int s = 0;
    for (int i = 0; i < NINT; i++) s += e_int_cnt[i];
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stb, input logic [33:0] word, input logic busy);
    bus_e.i_stb = stb; bus_e.i_word = word; bus_e.i_busy = busy;
    bus_l.i_stb = stb; bus_l.i_word = word; bus_l.i_busy = busy;
  endtask

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic stb, input logic [33:0] word, input logic busy,
                     input logic [3:0] irq_v, input logic e_stb,
                     input logic [33:0] e_word, input logic e_busy);
    vec_t v;
    v.stb = stb; v.word = word; v.busy = busy; v.irq = irq_v;
    v.e_stb = e_stb; v.e_word = e_word; v.e_busy = e_busy;
    vq.push_back(v);
  endtask

  task automatic idle();
    add(1'b0, '0, 1'b0, 4'h0, 1'b0, IW0, 1'b0);
  endtask

  initial begin
    int e1, l1, b0, it0, dt0;
    rst = 1'b1;
    irq = '0;
    drive(1'b0, '0, 1'b0);
    step();
    step();
    check("rst.stb", 34'(bus_e.o_int_stb), 34'(0));
    check("rst.word", bus_e.o_int_word, IW0);
    check("rst.busy", 34'(bus_e.o_int_busy), 34'(0));
    check("rst.lvl_stb", 34'(bus_l.o_int_stb), 34'(0));
    rst = 1'b0;

    add(1'b1, D1, 1'b0, 4'h0, 1'b1, D1, 1'b1);          // data word, one cycle
    idle(); idle();
    add(1'b0, '0, 1'b0, 4'b0100, 1'b0, IW0, 1'b0);      // ch2 pulse
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(2), 1'b0);
    idle(); idle(); idle();
    add(1'b0, '0, 1'b0, 4'b1001, 1'b0, IW0, 1'b0);      // ch0+ch3, pointer at 3
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(3), 1'b0);
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(0), 1'b0);
    idle(); idle();
    add(1'b0, '0, 1'b0, 4'b1000, 1'b0, IW0, 1'b0);      // ch3 alone moves pointer to 0
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(3), 1'b0);
    idle(); idle();
    add(1'b0, '0, 1'b0, 4'b1001, 1'b0, IW0, 1'b0);      // ch0+ch3, pointer at 0
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(0), 1'b0);
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(3), 1'b0);
    idle(); idle();
    add(1'b0, '0, 1'b0, 4'b0010, 1'b0, IW0, 1'b0);      // ch1, then stall and pre-empt
    add(1'b0, '0, 1'b1, 4'h0, 1'b1, iw(1), 1'b0);
    add(1'b0, '0, 1'b1, 4'h0, 1'b1, iw(1), 1'b0);
    add(1'b1, D2, 1'b1, 4'h0, 1'b1, D2, 1'b1);
    add(1'b0, '0, 1'b1, 4'h0, 1'b1, D2, 1'b1);
    add(1'b0, '0, 1'b0, 4'h0, 1'b1, iw(1), 1'b0);
    idle();

    foreach (vq[i]) begin
      drive(vq[i].stb, vq[i].word, vq[i].busy);
      irq = vq[i].irq;
      step();
      check($sformatf("v%0d.stb", i), 34'(bus_e.o_int_stb), 34'(vq[i].e_stb));
      if (vq[i].e_stb)
        check($sformatf("v%0d.word", i), bus_e.o_int_word, vq[i].e_word);
      else
        check($sformatf("v%0d.prefix", i), 34'(bus_e.o_int_word[33:29]), 34'(PFX));
      check($sformatf("v%0d.busy", i), 34'(bus_e.o_int_busy), 34'(vq[i].e_busy));
    end

    // Line held high for 100 cycles: edge mode reports once, level mode every other cycle
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    irq = '0;
    step();
    rst = 1'b0;
    e1 = e_int_cnt[1];
    l1 = l_int_cnt[1];
    b0 = l_b2b;
    irq = 4'b0010;
    repeat (100) step();
    irq = '0;
    repeat (10) step();
    check("hold.edge_cnt", 34'(e_int_cnt[1] - e1), 34'(1));
    check("hold.level_cnt", 34'(l_int_cnt[1] - l1), 34'(50));
    check("hold.level_b2b", 34'(l_b2b - b0), 34'(0));

    // Reset while a data word is stalled and two channels are pending
    drive(1'b1, D3, 1'b1);
    step();
    check("rs.stall_busy", 34'(bus_e.o_int_busy), 34'(1));
    check("rs.stall_word", bus_e.o_int_word, D3);
    drive(1'b0, '0, 1'b1);
    irq = 4'b0101;
    step();
    irq = '0;
    step();
    check("rs.still_stalled", 34'(bus_e.o_int_stb), 34'(1));
    it0 = e_int_total();
    dt0 = e_data_cnt;
    rst = 1'b1;
    step();
    check("rs.stb", 34'(bus_e.o_int_stb), 34'(0));
    check("rs.busy", 34'(bus_e.o_int_busy), 34'(0));
    check("rs.word", bus_e.o_int_word, IW0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("rs.quiet%0d", c), 34'(bus_e.o_int_stb), 34'(0));
    end
    check("rs.int_words", 34'(e_int_total() - it0), 34'(0));
    check("rs.data_words", 34'(e_data_cnt - dt0), 34'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbmultints.md
# hbmultints

Multi-channel interrupt inserter for the hexbus return path. It sits between the bus-response word stream and the hexbus output encoder. It merges up to NINT interrupt lines into the 34-bit word stream as tagged interrupt words. Data words always take precedence, and each interrupt event is reported exactly once.

## Interface
- NINT, 4: number of interrupt channels, 1..16.
- LGNINT, $clog2(NINT) (minimum 1): width of the channel tag.
- INT_PREFIX, 5'b11010: prefix that marks an interrupt word.
- OPT_LEVEL, 0: 0 selects rising-edge capture; 1 makes a channel re-pend while its line stays high.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_interrupt  in  NINT  raw interrupt lines, already synchronous to i_clk.
- i_stb  in  1  a data word is valid.
- i_word  in  34  data word; its bits [33:29] never equal INT_PREFIX.
- o_int_busy  out  1  back-pressure to the data source; equals o_int_stb && loaded.
- o_int_stb  out  1  the output word is valid.
- o_int_word  out  34  output word.
- i_busy  in  1  the downstream encoder is stalled.

## Operation
- Interrupt word for channel k: {INT_PREFIX, 29-LGNINT zero bits, k[LGNINT-1:0]}. The channel-0 word equals the legacy single-interrupt word.
- Per-channel armed[k] and pending[k] flags; both are 0 at reset.
  - If i_interrupt[k] && !armed[k]: set armed[k] and set pending[k].
  - Else if !pending[k] && !i_interrupt[k]: clear armed[k].
  - OPT_LEVEL=1: the armed check is dropped, so a high line re-sets pending[k] on every cycle in which pending[k] is clear.
- pending[k] clears when o_int_stb && !i_busy && int_loaded && tag==k. If a set and a clear fall in the same cycle, the set wins (only possible with OPT_LEVEL=1).
- Output register flags:
  - loaded = 1 while the register holds a data word.
  - int_loaded = 1 while it holds an interrupt word.
  - int_loaded == (o_int_word[33:29]==INT_PREFIX) at all times.
- Load priority, evaluated at each edge:
  1. Data: i_stb && !o_int_busy loads i_word and sets o_int_stb and loaded. The data word may overwrite a stalled interrupt word; that channel stays pending and is re-issued later.
  2. Interrupt: if there is no data load and (!o_int_stb || !i_busy), load the word of the granted channel. o_int_stb is set iff some channel remains pending after this cycle's clears.
  3. Otherwise hold. o_int_word and o_int_stb stay stable while o_int_stb && i_busy.
- Grant is round-robin over the pending flags, excluding any channel cleared this cycle. The pointer advances to the channel after the one most recently accepted.
- A channel whose word was just accepted cannot be granted on the next cycle. Back-to-back interrupt words from different channels are permitted.
- Reset values: o_int_stb=0; o_int_word = the channel-0 interrupt word; int_loaded=1; loaded=0; all pending and armed flags 0; round-robin pointer 0.

## Timing
- Data latency: i_stb accepted at edge t gives o_int_stb=1 with o_int_word=i_word after edge t.
- Interrupt latency: i_interrupt[k] rising before edge t sets pending[k] at t. The interrupt word can appear after edge t+1 if the output is idle.
- A stalled data word holds until i_busy falls. During the stall o_int_busy=1 and the data source must hold i_stb and i_word stable.
- A stalled interrupt word does not assert o_int_busy, so data may pre-empt it.
- Reset asserted mid-transfer drops any pending events. It also drops the data word held in the output register.

## Structure
- Put INT_PREFIX, the 34-bit word width and an interrupt-word construction function in shared include hb_defs.vh. The existing hexbus blocks use the same include.
- Sub-module hbintarb: NINT-wide round-robin arbiter with inputs request, advance and the accepted index, and outputs a one-hot grant plus the encoded grant.
- The formal properties for bus stability, single report per event and the int_loaded invariant live inside the module under `ifdef FORMAL`.

## Test plan
- Single data word, i_busy=0 → 34'h0_1234_5678 appears on o_int_word one cycle later with o_int_stb for exactly 1 cycle.
- Pulse i_interrupt[2] for 1 cycle while idle → exactly one word {11010, 0…, 2'd2}, and no repeat.
- i_interrupt[0] and i_interrupt[3] rise together, i_busy=0 → two consecutive words with tags 0 then 3. The next simultaneous event produces order 0 then 3 again only if the pointer is back at 0; otherwise 3 then 0.
- Interrupt word stalled by i_busy, then i_stb arrives → the data word replaces it. The interrupt word follows after the data word is accepted.
- i_interrupt[1] held high for 100 cycles → OPT_LEVEL=0 gives one word; OPT_LEVEL=1 gives repeated words, at most one per 2 cycles for that channel.
- Reset asserted while data is stalled and 2 channels are pending → the next cycle has o_int_stb=0 and no interrupt words after reset releases.
